// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM driver.
// Contents: angle width, +90 deg clamp value (Q16.16), default timing
// values for a 50 MHz clock, and the angle-to-duty coefficient function.
package servo_pkg;

  localparam int          XITA_W     = 32;
  localparam logic [31:0] XITA_MAX   = 32'h005A_0000;  // 90.0 deg
  localparam int          DEF_PERIOD = 1_000_000;
  localparam int          DEF_CENTER = 75_000;
  localparam int          DEF_SPAN   = 50_000;

  // ceil(span * 2^32 / (90 * 2^16)). Rounding up makes 90 deg * COEF >> 32
  // land exactly on span instead of span-1.
  function automatic logic [63:0] coef_calc(input int span);
    logic [63:0] num;
    num = 64'(span) << 32;
    return (num + 64'd5_898_240 - 64'd1) / 64'd5_898_240;
  endfunction

endpackage

// File: rtl/xita_duty_pipe.sv
// Angle-to-duty conversion pipeline for the servo driver.
// Stage 1 registers the clamped magnitude times COEF, plus sign and channel.
// Stage 2 is the combinational shift/add below; its result is registered by
// the parent into the pending duty of the addressed channel.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_valid    write accepted this cycle (channel already range-checked)
//   i_ch       target channel
//   i_xita     sign-magnitude Q15.16 angle
//   o_valid    stage-2 result valid
//   o_ch       stage-2 channel
//   o_duty     CENTER +/- offset
module xita_duty_pipe
  import servo_pkg::*;
#(
  parameter int CENTER = DEF_CENTER,
  parameter int SPAN   = DEF_SPAN,
  parameter int DUTY_W = 20,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [XITA_W-1:0] i_xita,
  output logic              o_valid,
  output logic [CH_W-1:0]   o_ch,
  output logic [DUTY_W-1:0] o_duty
);

  localparam logic [63:0] COEF = coef_calc(SPAN);

  logic [31:0]     w_mag_c;
  logic [31:0]     w_off;
  logic [31:0]     w_sum;
  logic            r_valid;
  logic            r_sign;
  logic [CH_W-1:0] r_ch;
  logic [63:0]     r_prod;

  // Clamp the magnitude to 90 deg so larger angles give exactly CENTER+-SPAN.
  always_comb begin
    w_mag_c = {1'b0, i_xita[30:0]};
    if ({1'b0, i_xita[30:0]} > XITA_MAX) begin
      w_mag_c = XITA_MAX;
    end else begin
      w_mag_c = {1'b0, i_xita[30:0]};
    end
  end

  // Stage 1 register: product, sign and channel sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sign  <= 1'b0;
      r_ch    <= {CH_W{1'b0}};
      r_prod  <= 64'd0;
    end else begin
      r_valid <= i_valid;
      r_sign  <= i_xita[31];
      r_ch    <= i_ch;
      r_prod  <= 64'(w_mag_c) * COEF;
    end
  end

  // Stage 2: offset in counts, applied around CENTER. A zero magnitude with
  // the sign bit set still gives CENTER.
  always_comb begin
    w_off = 32'(r_prod >> 32);
    if (r_sign) begin
      w_sum = 32'(CENTER) - w_off;
    end else begin
      w_sum = 32'(CENTER) + w_off;
    end
  end

  assign o_valid = r_valid;
  assign o_ch    = r_ch;
  assign o_duty  = DUTY_W'(w_sum);

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM driver: sign-magnitude Q15.16 angle writes in, one
// PWM pin per channel out. Duty changes take effect only at period
// boundaries, so a pulse is never cut short or stretched mid-period.
// Build option: define SERVO_SLEW_EN to limit the duty change per period to
// SLEW_STEP counts; otherwise the new duty applies in full at the boundary.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      angle write request
//   in_ready      write accepted this cycle if in_valid (low for the last two
//                 counts of each period and during reset)
//   in_ch         target channel
//   in_xita       angle, [31] sign, [30:0] Q15.16 magnitude in degrees
//   pwm_out       PWM outputs, one bit per channel
//   period_start  one-cycle pulse, registered from cnt==0
//   err_ch        sticky: a write addressed a channel >= N_CH
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int  N_CH      = 4,
  parameter int  PERIOD    = DEF_PERIOD,
  parameter int  CENTER    = DEF_CENTER,
  parameter int  SPAN      = DEF_SPAN,
  parameter int  DUTY_W    = 20,
  parameter int  SLEW_STEP = 5_000,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [XITA_W-1:0] in_xita,
  output logic [N_CH-1:0]   pwm_out,
  output logic              period_start,
  output logic              err_ch
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] CNT_GAP  = DUTY_W'(PERIOD - 2);
  localparam logic [DUTY_W-1:0] C_CENTER = DUTY_W'(CENTER);
  localparam logic [DUTY_W-1:0] C_STEP   = DUTY_W'(SLEW_STEP);

  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_pending [N_CH];
  logic [DUTY_W-1:0] r_active  [N_CH];
  logic [N_CH-1:0]   r_pwm;
  logic              r_period_start;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_ch_ok;
  logic              w_pipe_valid;
  logic [CH_W-1:0]   w_pipe_ch;
  logic [DUTY_W-1:0] w_pipe_duty;

  // Move a toward p by at most C_STEP, landing exactly on p.
  function automatic logic [DUTY_W-1:0] slew_to(input logic [DUTY_W-1:0] a,
                                                input logic [DUTY_W-1:0] p);
    logic [DUTY_W-1:0] r;
    if (p > a) begin
      if ((p - a) > C_STEP) r = a + C_STEP;
      else                  r = p;
    end else if (a > p) begin
      if ((a - p) > C_STEP) r = a - C_STEP;
      else                  r = p;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // The two-count ready gap lets a write accepted at PERIOD-3 reach pending
  // before the boundary transfer. in_ready depends only on cnt and rst.
  assign w_ready  = ~rst & (r_cnt < CNT_GAP);
  assign w_accept = in_valid & w_ready;
  assign w_ch_ok  = ({1'b0, in_ch} < (CH_W + 1)'(N_CH));

  xita_duty_pipe #(
    .CENTER (CENTER),
    .SPAN   (SPAN),
    .DUTY_W (DUTY_W),
    .CH_W   (CH_W)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept & w_ch_ok),
    .i_ch    (in_ch),
    .i_xita  (in_xita),
    .o_valid (w_pipe_valid),
    .o_ch    (w_pipe_ch),
    .o_duty  (w_pipe_duty)
  );

  // Period counter, period_start pulse, PWM compare and channel error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= {DUTY_W{1'b0}};
      r_period_start <= 1'b0;
      r_pwm          <= {N_CH{1'b0}};
      r_err          <= 1'b0;
    end else begin
      if (r_cnt == CNT_LAST) r_cnt <= {DUTY_W{1'b0}};
      else                   r_cnt <= r_cnt + DUTY_W'(1);
      r_period_start <= (r_cnt == {DUTY_W{1'b0}});
      for (int i = 0; i < N_CH; i++) begin
        r_pwm[i] <= (r_cnt < r_active[i]);
      end
      if (w_accept && !w_ch_ok) r_err <= 1'b1;
      else                      r_err <= r_err;
    end
  end

  // Pending duties (last write wins) and boundary transfer into active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_pending[i] <= C_CENTER;
        r_active[i]  <= C_CENTER;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_pipe_valid && (w_pipe_ch == CH_W'(i))) begin
          r_pending[i] <= w_pipe_duty;
        end
        if (r_cnt == CNT_LAST) begin
`ifdef SERVO_SLEW_EN
          r_active[i] <= slew_to(r_active[i], r_pending[i]);
`else
          r_active[i] <= r_pending[i];
`endif
        end
      end
    end
  end

  assign in_ready     = w_ready;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign err_ch       = r_err;

endmodule
